// File: rtl/icache_axi_pkg.sv
// Shared types and AXI constants for the icache line-fill reader.
package icache_axi_pkg;

  localparam int unsigned LINE_WORDS_DEF = 8;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/icache_axi_reader.sv
// Issues one INCR burst per icache line fill, collects the R beats into a
// line buffer and hands the whole line back with a one-cycle grant.
module icache_axi_reader
  import icache_axi_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_rd_req,
  input  logic [31:0] cache_addr,
  output logic        cache_gnt,
  output logic [31:0] line_data [0:LINE_WORDS-1],
  output logic        line_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned   CW   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  rd_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          full_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^cache_addr[4:0];

  assign arid    = AXI_ID;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;

  always_comb begin
    state_d   = state_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    cache_gnt = 1'b0;
    line_err  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (cache_rd_req) state_d = ST_AR;
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid && rlast) state_d = ST_DONE;
      end
      ST_DONE: begin
        cache_gnt = 1'b1;
        line_err  = err_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // full_q marks that the last slot has been written, so that a further beat
  // at the saturated counter is recognised as an overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      araddr  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      for (int unsigned i = 0; i < LINE_WORDS; i++) line_data[i] <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (cache_rd_req) begin
            araddr <= {cache_addr[31:5], 5'b0};
            cnt_q  <= '0;
            err_q  <= 1'b0;
            full_q <= 1'b0;
          end
        end
        ST_R: begin
          if (rvalid) begin
            line_data[cnt_q] <= rdata;
            if (rresp != RESP_OKAY) err_q <= 1'b1;
            if (cnt_q == LAST) begin
              if (full_q) err_q <= 1'b1;
              full_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
            if (rlast && (cnt_q != LAST)) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_axi_reader.sv
// Self-checking bench for icache_axi_reader with a randomized AXI slave and a
// line-level reference model.
module tb_icache_axi_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cache_rd_req = 1'b0;
  logic [31:0] cache_addr = '0;
  logic        cache_gnt;
  logic [31:0] line_data [8];
  logic        line_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  icache_axi_reader #(.LINE_WORDS(8), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst_n), .cache_rd_req(cache_rd_req), .cache_addr(cache_addr),
    .cache_gnt(cache_gnt), .line_data(line_data), .line_err(line_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int unsigned total = 0, passed = 0;

  // Reference model: the line as the icache should see it after a fill.
  logic [31:0] exp_line [8];
  bit          exp_err;

  // Observations from the last run_fill.
  int          r_ar_wait, r_gnt_cyc;
  bit          r_timeout, r_ar_ok, r_rready_ok, r_gnt, r_gnt_after, r_err;
  logic [31:0] r_araddr;
  logic [31:0] snap [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill(input logic [31:0] addr, input int nbeats, input int ar_delay,
                          input bit gaps, input int bad_beat, input bit seq_data,
                          input bit hold_req, input logic [31:0] next_addr);
    int c;
    logic [31:0] d;
    logic [1:0] resp;
    c = 0; r_timeout = 0; r_ar_ok = 1; r_rready_ok = 1; r_gnt = 0; r_gnt_after = 1;
    cache_rd_req = 1'b1;
    cache_addr = addr;
    step(); c++;
    if (hold_req) cache_addr = next_addr;
    else cache_rd_req = 1'b0;
    while (!arvalid && c < 20) begin step(); c++; end
    if (arvalid !== 1'b1) begin r_timeout = 1; return; end
    r_ar_wait = c;
    r_araddr = araddr;
    for (int i = 0; i <= ar_delay; i++) begin
      if (!(arvalid === 1'b1 && araddr === r_araddr && arlen === 8'd7 && arsize === 3'b010
            && arburst === 2'b01 && arid === 4'd0)) r_ar_ok = 0;
      if (i == ar_delay) arready = 1'b1;
      step(); c++;
    end
    arready = 1'b0;
    exp_err = 0;
    for (int k = 0; k < nbeats; k++) begin
      if (gaps && k > 0) begin
        rvalid = 1'b0; rdata = $urandom; rresp = 2'b11; rlast = 1'b1;
        step(); c++;
      end
      d = seq_data ? 32'h1000 + 32'(k) : $urandom;
      resp = (k == bad_beat) ? 2'b10 : 2'b00;
      rvalid = 1'b1; rdata = d; rresp = resp; rlast = (k == nbeats - 1);
      exp_line[(k < 8) ? k : 7] = d;
      if (resp != 2'b00) exp_err = 1;
      if (rready !== 1'b1) r_rready_ok = 0;
      step(); c++;
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    if (nbeats != 8) exp_err = 1;
    r_gnt = cache_gnt;
    r_err = line_err;
    r_gnt_cyc = c;
    snap = line_data;
    step();
    r_gnt_after = cache_gnt;
  endtask

  task automatic test_reset();
    #1;
    total++; if (arvalid !== 1'b0 || rready !== 1'b0) $display("FAIL reset_hs: arvalid=%0b rready=%0b expected 0 0", arvalid, rready); else passed++;
    total++; if (cache_gnt !== 1'b0 || line_err !== 1'b0) $display("FAIL reset_gnt: gnt=%0b err=%0b expected 0 0", cache_gnt, line_err); else passed++;
    total++; if (araddr !== 32'h0) $display("FAIL reset_araddr: got %h expected 0", araddr); else passed++;
    for (int i = 0; i < 8; i++) begin
      exp_line[i] = '0;
      total++; if (line_data[i] !== 32'h0) $display("FAIL reset_line[%0d]: got %h expected 0", i, line_data[i]); else passed++;
    end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    run_fill(32'hBFC0_0024, 8, 0, 0, -1, 1, 0, 32'h0);
    total++; if (r_timeout) $display("FAIL basic_timeout: arvalid never seen"); else passed++;
    total++; if (r_ar_wait != 1) $display("FAIL basic_ar_cycle: got %0d expected 1", r_ar_wait); else passed++;
    total++; if (r_araddr !== 32'hBFC0_0020) $display("FAIL basic_araddr: got %h expected bfc00020", r_araddr); else passed++;
    total++; if (!r_ar_ok) $display("FAIL basic_ar_fields: got bad arlen/arsize/arburst/arid expected 7/2/1/0"); else passed++;
    total++; if (r_gnt !== 1'b1 || r_gnt_cyc != 10) $display("FAIL basic_gnt: gnt=%0b cycle=%0d expected 1 at 10", r_gnt, r_gnt_cyc); else passed++;
    total++; if (r_gnt_after !== 1'b0) $display("FAIL basic_gnt_pulse: got %0b expected 0", r_gnt_after); else passed++;
    total++; if (r_err !== 1'b0) $display("FAIL basic_err: got %0b expected 0", r_err); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (snap[i] !== 32'h1000 + 32'(i)) $display("FAIL basic_line[%0d]: got %h expected %h", i, snap[i], 32'h1000 + 32'(i)); else passed++;
    end
  endtask

  task automatic test_backpressure();
    run_fill({$urandom} & 32'hFFFF_FFFC, 8, 5, 1, -1, 0, 0, 32'h0);
    total++; if (r_timeout) $display("FAIL bp_timeout: arvalid never seen"); else passed++;
    total++; if (!r_ar_ok) $display("FAIL bp_ar_stable: got unstable AR fields expected stable"); else passed++;
    total++; if (!r_rready_ok) $display("FAIL bp_rready: got rready low expected high during beats"); else passed++;
    total++; if (r_gnt !== 1'b1 || r_gnt_cyc != 22) $display("FAIL bp_gnt: gnt=%0b cycle=%0d expected 1 at 22", r_gnt, r_gnt_cyc); else passed++;
    total++; if (r_err !== exp_err || r_gnt_after !== 1'b0) $display("FAIL bp_err: err=%0b next_gnt=%0b expected %0b 0", r_err, r_gnt_after, exp_err); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (snap[i] !== exp_line[i]) $display("FAIL bp_line[%0d]: got %h expected %h", i, snap[i], exp_line[i]); else passed++;
    end
  endtask

  task automatic test_error();
    run_fill($urandom, 8, 0, 0, 3, 0, 0, 32'h0);
    total++; if (r_timeout) $display("FAIL err_timeout: arvalid never seen"); else passed++;
    total++; if (r_gnt !== 1'b1 || r_err !== 1'b1) $display("FAIL err_flag: gnt=%0b err=%0b expected 1 1", r_gnt, r_err); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (snap[i] !== exp_line[i]) $display("FAIL err_line[%0d]: got %h expected %h", i, snap[i], exp_line[i]); else passed++;
    end
  endtask

  task automatic test_short();
    run_fill($urandom, 8, 0, 0, -1, 0, 0, 32'h0);
    total++; if (r_timeout || r_err !== 1'b0) $display("FAIL short_prefill: timeout=%0b err=%0b expected 0 0", r_timeout, r_err); else passed++;
    run_fill($urandom, 6, 0, 0, -1, 0, 0, 32'h0);
    total++; if (r_gnt !== 1'b1 || r_gnt_cyc != 8) $display("FAIL short_gnt: gnt=%0b cycle=%0d expected 1 at 8", r_gnt, r_gnt_cyc); else passed++;
    total++; if (r_err !== 1'b1) $display("FAIL short_err: got %0b expected 1", r_err); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (snap[i] !== exp_line[i]) $display("FAIL short_line[%0d]: got %h expected %h", i, snap[i], exp_line[i]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int c;
    bit zero_ok;
    cache_rd_req = 1'b1; cache_addr = $urandom;
    step();
    cache_rd_req = 1'b0;
    c = 0;
    while (!arvalid && c < 20) begin step(); c++; end
    arready = 1'b1; step(); arready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rvalid = 1'b1; rdata = $urandom; rlast = 1'b0; step();
    end
    rdata = $urandom;
    #2 rst_n = 1'b0;
    #1;
    total++; if (arvalid !== 1'b0 || rready !== 1'b0 || cache_gnt !== 1'b0) $display("FAIL rstmid_outs: arvalid=%0b rready=%0b gnt=%0b expected 0 0 0", arvalid, rready, cache_gnt); else passed++;
    zero_ok = 1;
    for (int i = 0; i < 8; i++) begin
      exp_line[i] = '0;
      if (line_data[i] !== 32'h0) zero_ok = 0;
    end
    total++; if (!zero_ok) $display("FAIL rstmid_line: got nonzero words expected all 0"); else passed++;
    rvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step();
    run_fill($urandom, 8, 1, 0, -1, 0, 0, 32'h0);
    total++; if (r_timeout || r_gnt !== 1'b1 || r_err !== 1'b0) $display("FAIL rstmid_refill: timeout=%0b gnt=%0b err=%0b expected 0 1 0", r_timeout, r_gnt, r_err); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (snap[i] !== exp_line[i]) $display("FAIL rstmid_line[%0d]: got %h expected %h", i, snap[i], exp_line[i]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int extra_ar;
    run_fill(32'h2000_0100, 8, 0, 0, -1, 0, 1, 32'h0000_1040);
    total++; if (r_timeout || r_gnt !== 1'b1 || r_gnt_after !== 1'b0) $display("FAIL b2b_first: timeout=%0b gnt=%0b next_gnt=%0b expected 0 1 0", r_timeout, r_gnt, r_gnt_after); else passed++;
    total++; if (arvalid !== 1'b0) $display("FAIL b2b_idle: arvalid=%0b expected 0", arvalid); else passed++;
    run_fill(32'h0000_1040, 8, 0, 0, -1, 0, 0, 32'h0);
    total++; if (r_timeout || r_ar_wait != 1 || r_araddr !== 32'h0000_1040) $display("FAIL b2b_second_ar: wait=%0d araddr=%h expected 1 00001040", r_ar_wait, r_araddr); else passed++;
    total++; if (r_gnt !== 1'b1 || r_err !== 1'b0) $display("FAIL b2b_second_gnt: gnt=%0b err=%0b expected 1 0", r_gnt, r_err); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (snap[i] !== exp_line[i]) $display("FAIL b2b_line[%0d]: got %h expected %h", i, snap[i], exp_line[i]); else passed++;
    end
    extra_ar = 0;
    for (int i = 0; i < 6; i++) begin
      if (arvalid === 1'b1) extra_ar++;
      step();
    end
    total++; if (extra_ar != 0) $display("FAIL b2b_dup: got %0d extra AR cycles expected 0", extra_ar); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] a;
    int nb;
    for (int t = 0; t < 8; t++) begin
      a = $urandom;
      nb = int'($urandom_range(6, 9));
      run_fill(a, nb, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb - 1)) : -1, 0, 0, 32'h0);
      total++; if (r_timeout || r_araddr !== (a & 32'hFFFF_FFE0)) $display("FAIL rnd%0d_araddr: got %h expected %h", t, r_araddr, a & 32'hFFFF_FFE0); else passed++;
      total++; if (r_gnt !== 1'b1 || r_gnt_after !== 1'b0 || r_err !== exp_err) $display("FAIL rnd%0d_gnt: gnt=%0b next=%0b err=%0b expected 1 0 %0b", t, r_gnt, r_gnt_after, r_err, exp_err); else passed++;
      for (int i = 0; i < 8; i++) begin
        total++; if (snap[i] !== exp_line[i]) $display("FAIL rnd%0d_line[%0d]: got %h expected %h", t, i, snap[i], exp_line[i]); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_error();
    test_short();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
